ntt_mul_pipe: RTL and testbench

Pipelined unsigned integer multiplier that forms the double-width product consumed by the word-level modular reduction stage of the NTT butterfly datapath. It accepts one operand pair per cycle and returns the full 2·DATA_W product after a fixed 3-cycle latency. A parallel valid/tag delay line re-emits each tag aligned with the reduced result, RED_LAT cycles later. The butterfly controller uses that aligned tag as the memory write-back address.

---
 rtl/ntt_mul_pipe_if.sv | 26 ++
 rtl/ntt_mul_pipe.sv | 97 +++++++++
 tb/tb_ntt_mul_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_mul_pipe_if.sv
// Operand/product bundle between the butterfly controller and the NTT multiplier.
// The master side drives operands and tags, and the slave side returns the product and the aligned valid/tag taps.
interface ntt_mul_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  logic                  in_valid;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic [TAG_W-1:0]      in_tag;
  logic [2*DATA_W-1:0]   p;
  logic                  p_valid;
  logic [TAG_W-1:0]      p_tag;
  logic                  r_valid;
  logic [TAG_W-1:0]      r_tag;

  modport master (
    output in_valid, a, b, in_tag,
    input  p, p_valid, p_tag, r_valid, r_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag,
    output p, p_valid, p_tag, r_valid, r_tag
  );
endinterface

// File: rtl/ntt_mul_pipe.sv
// Three-stage unsigned half-split multiplier that feeds the modular reduction stage.
// A valid/tag delay line taps at the product and also RED_LAT cycles later, at the reduced result.
module ntt_mul_pipe #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 8,
  parameter int RED_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  ntt_mul_pipe_if.slave bus
);

  localparam int H     = DATA_W / 2;
  localparam int PW    = 2 * DATA_W;
  localparam int DEPTH = 3 + RED_LAT;

  logic [H-1:0]                  a_lo, a_hi, b_lo, b_hi;

  logic [DATA_W-1:0]             ll_p1_d, ll_p1_q;
  logic [DATA_W-1:0]             lh_p1_d, lh_p1_q;
  logic [DATA_W-1:0]             hl_p1_d, hl_p1_q;
  logic [DATA_W-1:0]             hh_p1_d, hh_p1_q;

  logic [DATA_W-1:0]             lo_p2_d, lo_p2_q;
  logic [DATA_W:0]               mid_p2_d, mid_p2_q;
  logic [DATA_W-1:0]             hi_p2_d, hi_p2_q;

  logic [PW-1:0]                 p_p3_d, p_p3_q;

  logic [DEPTH-1:0]              vld_d, vld_q;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_d, tag_q;

  function automatic logic [DATA_W-1:0] mul_half(input logic [H-1:0] x, input logic [H-1:0] y);
    return {{H{1'b0}}, x} * {{H{1'b0}}, y};
  endfunction

  // The carry bit of mid lands at bit 2H+H, so it is kept when mid is shifted into place.
  function automatic logic [PW-1:0] recombine(input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W:0]   mid,
                                              input logic [DATA_W-1:0] lo);
    return {hi, lo} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
  endfunction

  assign a_lo = bus.a[H-1:0];
  assign a_hi = bus.a[DATA_W-1:H];
  assign b_lo = bus.b[H-1:0];
  assign b_hi = bus.b[DATA_W-1:H];

  always_comb begin
    // Stage 1: partial products
    ll_p1_d  = mul_half(a_lo, b_lo);
    lh_p1_d  = mul_half(a_lo, b_hi);
    hl_p1_d  = mul_half(a_hi, b_lo);
    hh_p1_d  = mul_half(a_hi, b_hi);
    // Stage 2: fold the cross terms
    lo_p2_d  = ll_p1_q;
    mid_p2_d = {1'b0, lh_p1_q} + {1'b0, hl_p1_q};
    hi_p2_d  = hh_p1_q;
    // Stage 3: full-width product
    p_p3_d   = recombine(hi_p2_q, mid_p2_q, lo_p2_q);
    vld_d    = {vld_q[DEPTH-2:0], bus.in_valid};
    tag_d    = {tag_q[DEPTH-2:0], bus.in_tag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ll_p1_q  <= '0;
      lh_p1_q  <= '0;
      hl_p1_q  <= '0;
      hh_p1_q  <= '0;
      lo_p2_q  <= '0;
      mid_p2_q <= '0;
      hi_p2_q  <= '0;
      p_p3_q   <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
    end else begin
      ll_p1_q  <= ll_p1_d;
      lh_p1_q  <= lh_p1_d;
      hl_p1_q  <= hl_p1_d;
      hh_p1_q  <= hh_p1_d;
      lo_p2_q  <= lo_p2_d;
      mid_p2_q <= mid_p2_d;
      hi_p2_q  <= hi_p2_d;
      p_p3_q   <= p_p3_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.p       = p_p3_q;
  assign bus.p_valid = vld_q[2];
  assign bus.p_tag   = tag_q[2];
  assign bus.r_valid = vld_q[DEPTH-1];
  assign bus.r_tag   = tag_q[DEPTH-1];

endmodule

// File: tb/tb_ntt_mul_pipe.sv
// Directed bench for ntt_mul_pipe. It runs RED_LAT=1, 3 and 6 builds side by side on identical stimulus.
// A small p mod Q reduction model sits behind each build so that r_tag can be cross-checked.
module tb_ntt_mul_pipe;
  localparam logic [63:0] Q = 64'd3329;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ntt_mul_pipe_if #(.DATA_W(32), .TAG_W(8)) if1 ();
  ntt_mul_pipe_if #(.DATA_W(32), .TAG_W(8)) if3 ();
  ntt_mul_pipe_if #(.DATA_W(32), .TAG_W(8)) if6 ();

  ntt_mul_pipe #(.DATA_W(32), .TAG_W(8), .RED_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  ntt_mul_pipe #(.DATA_W(32), .TAG_W(8), .RED_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
  ntt_mul_pipe #(.DATA_W(32), .TAG_W(8), .RED_LAT(6)) u6 (.clk(clk), .reset(reset), .bus(if6));

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_c [256];
  logic [63:0] c1_q;
  logic [63:0] c3_q [3];
  logic [63:0] c6_q [6];

  logic        hv [80];
  logic [31:0] ha [80];
  logic [31:0] hb [80];
  logic [7:0]  ht [80];

  // Reduction-stage models: C = p mod Q, delayed by RED_LAT registers.
  always @(posedge clk) begin
    c1_q    <= if1.p % Q;
    c3_q[0] <= if3.p % Q;
    c3_q[1] <= c3_q[0];
    c3_q[2] <= c3_q[1];
    c6_q[0] <= if6.p % Q;
    for (int i = 1; i < 6; i++) c6_q[i] <= c6_q[i-1];
  end

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [7:0] t);
    if1.in_valid = v; if1.a = x; if1.b = y; if1.in_tag = t;
    if3.in_valid = v; if3.a = x; if3.b = y; if3.in_tag = t;
    if6.in_valid = v; if6.a = x; if6.b = y; if6.in_tag = t;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++; if (if3.p !== 64'h0) begin n_fail++; $display("FAIL reset_p: got %h expected 0", if3.p); end
    n_checks++; if (if3.p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b expected 0", if3.p_valid); end
    n_checks++; if (if3.p_tag !== 8'h0) begin n_fail++; $display("FAIL reset_p_tag: got %h expected 0", if3.p_tag); end
    n_checks++; if (if3.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b expected 0", if3.r_valid); end
    n_checks++; if (if3.r_tag !== 8'h0) begin n_fail++; $display("FAIL reset_r_tag: got %h expected 0", if3.r_tag); end
    n_checks++; if (if1.r_valid !== 1'b0 || if6.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_r_valid_1_6: got %b/%b expected 0/0", if1.r_valid, if6.r_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    @(negedge clk);
    drive(1'b1, 32'd3, 32'd5, 8'h11);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 8'h0);
      n_checks++; if (if3.p_valid !== (c == 3)) begin n_fail++; $display("FAIL basic_p_valid c=%0d: got %b", c, if3.p_valid); end
      if (c == 3) begin
        n_checks++; if (if3.p !== 64'd15) begin n_fail++; $display("FAIL basic_p: got %0d expected 15", if3.p); end
        n_checks++; if (if3.p_tag !== 8'h11) begin n_fail++; $display("FAIL basic_p_tag: got %h expected 11", if3.p_tag); end
      end
      n_checks++; if (if3.r_valid !== (c == 6)) begin n_fail++; $display("FAIL basic_r_valid c=%0d: got %b", c, if3.r_valid); end
      if (c == 6) begin
        n_checks++; if (if3.r_tag !== 8'h11) begin n_fail++; $display("FAIL basic_r_tag: got %h expected 11", if3.r_tag); end
      end
      n_checks++; if (if1.r_valid !== (c == 4)) begin n_fail++; $display("FAIL basic_r1_valid c=%0d: got %b", c, if1.r_valid); end
      n_checks++; if (if6.r_valid !== (c == 9)) begin n_fail++; $display("FAIL basic_r6_valid c=%0d: got %b", c, if6.r_valid); end
      if (c == 9) begin
        n_checks++; if (if6.r_tag !== 8'h11) begin n_fail++; $display("FAIL basic_r6_tag: got %h expected 11", if6.r_tag); end
      end
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [63:0] vp [5];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vp[0] = 64'hFFFF_FFFE_0000_0001;
    va[1] = 32'h0000_FFFF; vb[1] = 32'hFFFF_0000; vp[1] = 64'h0000_FFFE_0001_0000;
    va[2] = 32'h0001_0000; vb[2] = 32'h0001_0000; vp[2] = 64'h0000_0001_0000_0000;
    va[3] = 32'h0000_0000; vb[3] = 32'hFFFF_FFFF; vp[3] = 64'h0;
    va[4] = 32'h0000_0001; vb[4] = 32'hFFFF_FFFF; vp[4] = 64'h0000_0000_FFFF_FFFF;
    for (int c = 0; c <= 12; c++) begin
      int j;
      @(negedge clk);
      j = c - 3;
      if (j >= 0 && j < 5) begin
        n_checks++; if (if3.p_valid !== 1'b1) begin n_fail++; $display("FAIL bound_p_valid[%0d]: got %b expected 1", j, if3.p_valid); end
        n_checks++; if (if3.p !== vp[j]) begin n_fail++; $display("FAIL bound_p[%0d]: got %h expected %h", j, if3.p, vp[j]); end
        n_checks++; if (if3.p_tag !== 8'(8'h21 + j)) begin n_fail++; $display("FAIL bound_p_tag[%0d]: got %h expected %h", j, if3.p_tag, 8'(8'h21 + j)); end
      end else begin
        n_checks++; if (if3.p_valid !== 1'b0) begin n_fail++; $display("FAIL bound_p_idle c=%0d: got %b expected 0", c, if3.p_valid); end
      end
      if (c < 5) drive(1'b1, va[c], vb[c], 8'(8'h21 + c));
      else       drive(1'b0, 32'h0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 80; c++) begin
      hv[c] = (c < 64) || (c >= 66 && c < 70);
      ha[c] = $urandom;
      hb[c] = $urandom;
      ht[c] = (c < 64) ? 8'(c) : 8'(c - 2);
      if (hv[c]) exp_c[ht[c]] = (({32'h0, ha[c]} * {32'h0, hb[c]}) % Q);
    end
    ha[0] = 32'hFFFF_FFFF; hb[0] = 32'hFFFF_FFFF;
    exp_c[0] = (64'hFFFF_FFFE_0000_0001 % Q);
    for (int c = 0; c < 80; c++) begin
      int j3, j6;
      logic e3, e6;
      logic [63:0] prod;
      @(negedge clk);
      j3 = c - 3;
      j6 = c - 6;
      e3 = (j3 >= 0) ? hv[j3] : 1'b0;
      e6 = (j6 >= 0) ? hv[j6] : 1'b0;
      n_checks++; if (if3.p_valid !== e3) begin n_fail++; $display("FAIL stream_p_valid c=%0d: got %b expected %b", c, if3.p_valid, e3); end
      if (e3) begin
        prod = {32'h0, ha[j3]} * {32'h0, hb[j3]};
        n_checks++; if (if3.p !== prod) begin n_fail++; $display("FAIL stream_p c=%0d: got %h expected %h", c, if3.p, prod); end
        n_checks++; if (if3.p_tag !== ht[j3]) begin n_fail++; $display("FAIL stream_p_tag c=%0d: got %h expected %h", c, if3.p_tag, ht[j3]); end
      end
      n_checks++; if (if3.r_valid !== e6) begin n_fail++; $display("FAIL stream_r_valid c=%0d: got %b expected %b", c, if3.r_valid, e6); end
      if (e6) begin
        n_checks++; if (if3.r_tag !== ht[j6]) begin n_fail++; $display("FAIL stream_r_tag c=%0d: got %h expected %h", c, if3.r_tag, ht[j6]); end
        n_checks++; if (c3_q[2] !== exp_c[if3.r_tag]) begin n_fail++; $display("FAIL stream_red3 c=%0d: got %0d expected %0d", c, c3_q[2], exp_c[if3.r_tag]); end
      end
      if (hv[c]) drive(1'b1, ha[c], hb[c], ht[c]);
      else       drive(1'b0, ha[c], hb[c], 8'hEE);
    end
  endtask

  task automatic test_red_lat;
    // Pairs at cycles 0..3 and 6..7; bubbles at 4..5 must trail through both taps.
    for (int c = 0; c < 20; c++) begin
      hv[c] = (c < 4) || (c == 6) || (c == 7);
      ha[c] = $urandom;
      hb[c] = $urandom;
      ht[c] = 8'(8'h80 + c);
      if (hv[c]) exp_c[ht[c]] = (({32'h0, ha[c]} * {32'h0, hb[c]}) % Q);
    end
    for (int c = 0; c < 20; c++) begin
      int j1, j6;
      logic e1, e6;
      @(negedge clk);
      j1 = c - 4;
      j6 = c - 9;
      e1 = (j1 >= 0) ? hv[j1] : 1'b0;
      e6 = (j6 >= 0) ? hv[j6] : 1'b0;
      n_checks++; if (if1.r_valid !== e1) begin n_fail++; $display("FAIL rl1_r_valid c=%0d: got %b expected %b", c, if1.r_valid, e1); end
      if (e1) begin
        n_checks++; if (if1.r_tag !== ht[j1]) begin n_fail++; $display("FAIL rl1_r_tag c=%0d: got %h expected %h", c, if1.r_tag, ht[j1]); end
        n_checks++; if (c1_q !== exp_c[if1.r_tag]) begin n_fail++; $display("FAIL rl1_red c=%0d: got %0d expected %0d", c, c1_q, exp_c[if1.r_tag]); end
      end
      n_checks++; if (if6.r_valid !== e6) begin n_fail++; $display("FAIL rl6_r_valid c=%0d: got %b expected %b", c, if6.r_valid, e6); end
      if (e6) begin
        n_checks++; if (if6.r_tag !== ht[j6]) begin n_fail++; $display("FAIL rl6_r_tag c=%0d: got %h expected %h", c, if6.r_tag, ht[j6]); end
        n_checks++; if (c6_q[5] !== exp_c[if6.r_tag]) begin n_fail++; $display("FAIL rl6_red c=%0d: got %0d expected %0d", c, c6_q[5], exp_c[if6.r_tag]); end
      end
      if (hv[c]) drive(1'b1, ha[c], hb[c], ht[c]);
      else       drive(1'b0, 32'h0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 32'(c + 1), 32'(c + 2), 8'(8'h40 + c));
    end
    @(negedge clk);
    drive(1'b1, 32'd100, 32'd100, 8'h45);
    reset = 1'b1;
    #1;
    n_checks++; if (if3.p !== 64'h0 || if3.p_tag !== 8'h0) begin
      n_fail++; $display("FAIL midrst_p: got p=%h tag=%h expected 0/0", if3.p, if3.p_tag); end
    n_checks++; if (if3.p_valid !== 1'b0 || if3.r_valid !== 1'b0 || if3.r_tag !== 8'h0) begin
      n_fail++; $display("FAIL midrst_valid: got p_valid=%b r_valid=%b r_tag=%h expected 0", if3.p_valid, if3.r_valid, if3.r_tag); end
    n_checks++; if (if1.r_valid !== 1'b0 || if6.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_r_1_6: got %b/%b expected 0/0", if1.r_valid, if6.r_valid); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'd7, 32'd9, 8'h5A);
    for (int c = 7; c <= 17; c++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 8'h0);
      n_checks++; if (if3.p_valid !== (c == 9)) begin n_fail++; $display("FAIL midrst_p_valid c=%0d: got %b", c, if3.p_valid); end
      if (c == 9) begin
        n_checks++; if (if3.p !== 64'd63) begin n_fail++; $display("FAIL midrst_p63: got %0d expected 63", if3.p); end
        n_checks++; if (if3.p_tag !== 8'h5A) begin n_fail++; $display("FAIL midrst_p_tag: got %h expected 5a", if3.p_tag); end
      end
      n_checks++; if (if3.r_valid !== (c == 12)) begin n_fail++; $display("FAIL midrst_r3 c=%0d: got %b", c, if3.r_valid); end
      n_checks++; if (if1.r_valid !== (c == 10)) begin n_fail++; $display("FAIL midrst_r1 c=%0d: got %b", c, if1.r_valid); end
      n_checks++; if (if6.r_valid !== (c == 15)) begin n_fail++; $display("FAIL midrst_r6 c=%0d: got %b", c, if6.r_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_red_lat();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
